// File: rtl/hazard_fwd_unit.sv
// Load-use stall, branch flush, EX-busy hold and operand forwarding control for the pipeline.
// Optional stall statistics counters are built in when HAZARD_STATS_EN is defined.
module hazard_fwd_unit #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [ADDR_W-1:0] id_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              branch_flush,
    input  logic              ex_busy,
    output logic              riskSig,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
`ifdef HAZARD_STATS_EN
    output logic [STAT_W-1:0] lu_stall_cnt,
    output logic [STAT_W-1:0] hold_cnt,
`endif
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StLuStall = 2'b01,
        StHold    = 2'b10
    } stateE;

    stateE             stateQ;
    logic [ADDR_W-1:0] exRsQ, exRtQ, exDstQ;
    logic              exRwQ, exMrQ;
    logic [ADDR_W-1:0] memDstQ, wbDstQ;
    logic              memRwQ, wbRwQ;
    logic              loadUse;
    logic              bubble;

    // MEM result is newer than WB, so it wins when both match.
    function automatic logic [1:0] fwdSel(input logic [ADDR_W-1:0] src,
                                          input logic [ADDR_W-1:0] memDst,
                                          input logic              memRw,
                                          input logic [ADDR_W-1:0] wbDst,
                                          input logic              wbRw);
        logic [1:0] sel;
        sel = 2'b00;
        if (memRw && memDst != '0 && memDst == src) begin
            sel = 2'b01;
        end else if (wbRw && wbDst != '0 && wbDst == src) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        loadUse = exMrQ && exDstQ != '0 &&
                  (exDstQ == id_rs || (id_uses_rt && exDstQ == id_rt));
        riskSig    = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        if (ex_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (branch_flush) begin
            ifid_flush = 1'b1;
        end else if (loadUse) begin
            riskSig    = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end
        fwd_a  = fwdSel(exRsQ, memDstQ, memRwQ, wbDstQ, wbRwQ);
        fwd_b  = fwdSel(exRtQ, memDstQ, memRwQ, wbDstQ, wbRwQ);
        bubble = riskSig || branch_flush;
    end

    assign state = stateQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ  <= StRun;
            exRsQ   <= '0;
            exRtQ   <= '0;
            exDstQ  <= '0;
            exRwQ   <= 1'b0;
            exMrQ   <= 1'b0;
            memDstQ <= '0;
            memRwQ  <= 1'b0;
            wbDstQ  <= '0;
            wbRwQ   <= 1'b0;
        end else begin
            if (ex_busy) begin
                stateQ <= StHold;
            end else if (branch_flush) begin
                stateQ <= StRun;
            end else if (loadUse) begin
                stateQ <= StLuStall;
            end else begin
                stateQ <= StRun;
            end

            // The whole shadow pipeline freezes while EX is busy.
            if (!ex_busy) begin
                wbDstQ  <= memDstQ;
                wbRwQ   <= memRwQ;
                memDstQ <= exDstQ;
                memRwQ  <= exRwQ;
                if (bubble) begin
                    exRsQ  <= '0;
                    exRtQ  <= '0;
                    exDstQ <= '0;
                    exRwQ  <= 1'b0;
                    exMrQ  <= 1'b0;
                end else begin
                    exRsQ  <= id_rs;
                    exRtQ  <= id_rt;
                    exDstQ <= id_dst;
                    exRwQ  <= id_reg_write;
                    exMrQ  <= id_mem_read;
                end
            end
        end
    end

`ifdef HAZARD_STATS_EN
    // Saturating counters: hold at all-ones rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_stall_cnt <= '0;
            hold_cnt     <= '0;
        end else begin
            if (riskSig && lu_stall_cnt != '1) begin
                lu_stall_cnt <= lu_stall_cnt + STAT_W'(1);
            end
            if (ex_busy && hold_cnt != '1) begin
                hold_cnt <= hold_cnt + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed-vector bench for hazard_fwd_unit: stimulus pushes expected outputs into a queue,
// a negedge monitor pops and compares them.
module tb_hazard_fwd_unit;

    localparam logic [1:0] RUN  = 2'b00;
    localparam logic [1:0] LUS  = 2'b01;
    localparam logic [1:0] HOLD = 2'b10;

    typedef struct packed {
        logic [3:0] ctl;   // {riskSig, pc_write, ifid_write, ifid_flush}
        logic [1:0] fa;
        logic [1:0] fb;
        logic [1:0] st;
    } expT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;
    logic       id_uses_rt = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;
    logic       branch_flush = 1'b0, ex_busy = 1'b0;
    logic       riskSig, pc_write, ifid_write, ifid_flush;
    logic [1:0] fwd_a, fwd_b, state;
`ifdef HAZARD_STATS_EN
    logic [15:0] lu_stall_cnt, hold_cnt;
`endif

    hazard_fwd_unit #(.ADDR_W(5), .STAT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .id_dst       (id_dst),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .branch_flush (branch_flush),
        .ex_busy      (ex_busy),
        .riskSig      (riskSig),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
`ifdef HAZARD_STATS_EN
        .lu_stall_cnt (lu_stall_cnt),
        .hold_cnt     (hold_cnt),
`endif
        .state        (state)
    );

    always #5 clk = ~clk;

    expT expQ[$];
    int  tagQ[$];
    int  vecNum = 0;
    int  total = 0;
    int  passed = 0;

    task automatic step(input logic rn, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ur, input logic [4:0] dst, input logic rw, input logic mr,
                        input logic fl, input logic bz, input logic [3:0] ctl,
                        input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] st);
        expT e;
        @(posedge clk);
        #1;
        rst_n        = rn;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rt   = ur;
        id_dst       = dst;
        id_reg_write = rw;
        id_mem_read  = mr;
        branch_flush = fl;
        ex_busy      = bz;
        e.ctl = ctl;
        e.fa  = fa;
        e.fb  = fb;
        e.st  = st;
        expQ.push_back(e);
        tagQ.push_back(vecNum);
        vecNum++;
    endtask

    always @(negedge clk) begin
        if (expQ.size() != 0) begin
            expT e;
            expT got;
            int  tag;
            e   = expQ.pop_front();
            tag = tagQ.pop_front();
            got.ctl = {riskSig, pc_write, ifid_write, ifid_flush};
            got.fa  = fwd_a;
            got.fb  = fwd_b;
            got.st  = state;
            total++;
            if (got === e) begin
                passed++;
            end else begin
                $display("FAIL vec%0d: got ctl=%b fa=%b fb=%b st=%b, want ctl=%b fa=%b fb=%b st=%b",
                         tag, got.ctl, got.fa, got.fb, got.st, e.ctl, e.fa, e.fb, e.st);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        // rn   rs  rt ur dst rw mr fl bz  ctl       fa     fb     st
        step(1,  0,  0, 0,  0, 0, 0, 0, 0, 4'b0110, 2'b00, 2'b00, RUN);   // after reset
        step(1,  2,  8, 0,  8, 1, 1, 0, 0, 4'b0110, 2'b00, 2'b00, RUN);   // lw r8
        step(1,  8,  9, 1, 10, 1, 0, 0, 0, 4'b1000, 2'b00, 2'b00, RUN);   // add r8: load-use
        step(1,  8,  9, 1, 10, 1, 0, 0, 0, 4'b0110, 2'b00, 2'b00, LUS);   // bubble in EX
        step(1,  1,  2, 1,  3, 1, 0, 0, 0, 4'b0110, 2'b10, 2'b00, RUN);   // add in EX: WB fwd
        step(1,  3,  3, 1,  3, 1, 0, 0, 0, 4'b0110, 2'b00, 2'b00, RUN);   // sub r3,r3 -> r3
        step(1,  3,  5, 1,  6, 1, 0, 0, 0, 4'b0110, 2'b01, 2'b01, RUN);   // sub in EX: MEM fwd
        step(1,  0,  0, 0,  0, 1, 1, 0, 0, 4'b0110, 2'b01, 2'b00, RUN);   // r3 in MEM+WB: MEM
        step(1,  0,  0, 1,  7, 1, 0, 0, 0, 4'b0110, 2'b00, 2'b00, RUN);   // r0 load: no stall
        step(1,  2,  8, 0,  8, 1, 1, 0, 0, 4'b0110, 2'b00, 2'b00, RUN);   // r0 in MEM: no fwd
        step(1,  9,  8, 1, 10, 1, 0, 1, 0, 4'b0111, 2'b00, 2'b00, RUN);   // lu + flush
        step(1,  1,  5, 0,  5, 1, 1, 0, 0, 4'b0110, 2'b00, 2'b00, RUN);   // lw r5
        step(1,  5,  8, 1,  9, 1, 0, 0, 1, 4'b0000, 2'b00, 2'b00, RUN);   // busy 1 (lu masked)
        step(1,  5,  8, 1,  9, 1, 0, 0, 1, 4'b0000, 2'b00, 2'b00, HOLD);  // busy 2
        step(1,  5,  8, 1,  9, 1, 0, 0, 1, 4'b0000, 2'b00, 2'b00, HOLD);  // busy 3
        step(1,  5,  8, 1,  9, 1, 0, 0, 0, 4'b1000, 2'b00, 2'b00, HOLD);  // pending lu re-stalls
        step(1,  5,  8, 1,  9, 1, 0, 0, 0, 4'b0110, 2'b00, 2'b00, LUS);
        step(1,  5,  4, 0,  4, 1, 1, 0, 0, 4'b0110, 2'b10, 2'b00, RUN);   // lw r4, r5 from WB
        step(1,  4,  0, 0,  6, 1, 0, 0, 1, 4'b0000, 2'b00, 2'b00, RUN);   // busy with lu pending
        step(1,  4,  0, 0,  6, 1, 0, 0, 1, 4'b0000, 2'b00, 2'b00, HOLD);
        step(0,  4,  0, 0,  6, 1, 0, 0, 0, 4'b0110, 2'b00, 2'b00, RUN);   // reset mid-hold
        step(1,  4,  0, 0,  6, 1, 0, 0, 0, 4'b0110, 2'b00, 2'b00, RUN);   // shadow cleared
        for (int i = 0; i < 10 && expQ.size() != 0; i++) begin
            @(posedge clk);
        end
        if (expQ.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending, want 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
